// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and default widths for the CPU instruction sequencer
package cpu_seq_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, CAPTURE, FINISH} seq_state_t;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] opcode;
    logic [DEF_DATA_WIDTH-1:0] a;
    logic [DEF_DATA_WIDTH-1:0] b;
  } instr_t;
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: single write port memory with a combinational read port
module seq_regfile #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: issues a loaded {opcode,A,B} program to the CPU and buffers each Y
module cpu_instr_sequencer import cpu_seq_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RES_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [3*DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH:0]     prog_len,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    wr,
  output logic [DATA_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   B,
  output logic [DATA_WIDTH-1:0]   opcode,
  input  logic [DATA_WIDTH-1:0]   Y,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  localparam int CW = RES_LAT > 1 ? $clog2(RES_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RES_LAT - 1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;
  seq_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3*DATA_WIDTH-1:0] ir_q, ir_d, prog_word;
  logic wr_q, last_cap, last_instr;
  seq_regfile #(.WIDTH(3*DATA_WIDTH), .AW(ADDR_WIDTH)) u_prog (
    .clk(clk), .we_i(load_en && state_q == IDLE), .waddr_i(load_addr),
    .wdata_i(load_data), .raddr_i(pc_q), .rdata_o(prog_word)
  );
  seq_regfile #(.WIDTH(DATA_WIDTH), .AW(ADDR_WIDTH)) u_res (
    .clk(clk), .we_i(last_cap), .waddr_i(pc_q),
    .wdata_i(Y), .raddr_i(rd_addr), .rdata_o(rd_data)
  );
  assign last_cap   = state_q == CAPTURE && cnt_q == LAST;
  assign last_instr = {1'b0, pc_q} == len_q - LEN_ONE;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: if (start) begin
        len_d   = prog_len;
        pc_d    = '0;
        state_d = prog_len == '0 ? FINISH : FETCH;
      end
      FETCH: begin
        ir_d    = prog_word;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = last_cap ? (last_instr ? FINISH : FETCH) : CAPTURE;
        pc_d    = last_cap && !last_instr ? pc_q + ADDR_WIDTH'(1) : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      wr_q    <= state_q == ISSUE;
    end
  end
  // operands are only driven during the single registered write-strobe cycle
  assign wr     = wr_q;
  assign opcode = wr_q ? ir_q[2*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign A      = wr_q ? ir_q[DATA_WIDTH +: DATA_WIDTH] : '0;
  assign B      = wr_q ? ir_q[0 +: DATA_WIDTH] : '0;
  assign busy   = state_q inside {FETCH, ISSUE, CAPTURE};
  assign done   = state_q == FINISH;
endmodule
